// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
//
// Receive-side partner of the serial XNOR LFSR pattern generator. It learns the
// generator phase from the first WIDTH received bits (SEED), then predicts each
// following bit from the recurrence s(n) = ~(s(n-WIDTH) ^ s(n-WIDTH+1)) and
// flags every bit that disagrees (CHECK). Too many errors inside one window of
// checked bits drops lock and forces a reseed.
//
// WIDTH must be at least 2, because the prediction taps two history bits.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   linein     in   serial bit from the generator line output
//   enable     in   bit strobe; linein is sampled only when enable=1
//   clear      in   synchronous clear of err_count (lock state untouched)
//   locked     out  high while in CHECK
//   bit_err    out  one-cycle pulse after a mismatched bit
//   err_count  out  saturating count of mismatches since reset or clear
//   lock_lost  out  one-cycle pulse on the CHECK->SEED transition
//   stuck      out  high while locked and the history is all ones
// -----------------------------------------------------------------------------
module lfsr_checker #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned ERR_W       = 16,
    parameter int unsigned WINDOW      = 16,
    parameter int unsigned LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             linein,
    input  logic             enable,
    input  logic             clear,
    output logic             locked,
    output logic             bit_err,
    output logic [ERR_W-1:0] err_count,
    output logic             lock_lost,
    output logic             stuck
);

    // Counter widths sized so each counter can hold its terminal value.
    localparam int unsigned SEED_W = $clog2(WIDTH + 1);
    localparam int unsigned WCNT_W = $clog2(WINDOW + 1);
    localparam int unsigned WERR_W = $clog2(LOSS_THRESH + 1);

    localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(WIDTH - 1);
    localparam logic [WCNT_W-1:0] WIN_LAST  = WCNT_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0] ERR_LIMIT = WERR_W'(LOSS_THRESH);

    typedef enum logic [0:0] {
        StSeed,
        StCheck
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   hist_q;       // hist_q[0] is the newest received bit
    logic [SEED_W-1:0]  seed_cnt_q;
    logic [WCNT_W-1:0]  win_cnt_q;
    logic [WERR_W-1:0]  win_err_q;
    logic [ERR_W-1:0]   err_count_q;
    logic               bit_err_q;
    logic               lock_lost_q;

    logic               pred;
    logic               mismatch;
    logic [WERR_W-1:0]  win_err_inc;
    logic               hit_thresh;
    logic               win_end;
    logic               err_sat;
    logic               count_err;

    always_comb begin
        pred        = ~(hist_q[WIDTH-1] ^ hist_q[WIDTH-2]);
        mismatch    = (linein != pred);
        win_err_inc = win_err_q + WERR_W'(mismatch);
        hit_thresh  = (win_err_inc == ERR_LIMIT);
        win_end     = (win_cnt_q == WIN_LAST);
        err_sat     = &err_count_q;
        count_err   = enable && (state_q == StCheck) && mismatch && !err_sat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StSeed;
            hist_q      <= '0;
            seed_cnt_q  <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_count_q <= '0;
            bit_err_q   <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            // Pulses default low; they are only raised by an enabled bit.
            bit_err_q   <= 1'b0;
            lock_lost_q <= 1'b0;

            if (enable) begin
                // History always tracks what was received, never the prediction,
                // so one line error also corrupts the next two predictions.
                hist_q <= {hist_q[WIDTH-2:0], linein};

                unique case (state_q)
                    StSeed: begin
                        if (seed_cnt_q == SEED_LAST) begin
                            state_q    <= StCheck;
                            seed_cnt_q <= '0;
                            win_cnt_q  <= '0;
                            win_err_q  <= '0;
                        end else begin
                            seed_cnt_q <= seed_cnt_q + SEED_W'(1);
                        end
                    end

                    StCheck: begin
                        bit_err_q <= mismatch;
                        if (hit_thresh) begin
                            // Threshold beats the window rollover on the same bit.
                            lock_lost_q <= 1'b1;
                            state_q     <= StSeed;
                            seed_cnt_q  <= '0;
                            win_cnt_q   <= '0;
                            win_err_q   <= '0;
                        end else if (win_end) begin
                            win_cnt_q <= '0;
                            win_err_q <= '0;
                        end else begin
                            win_cnt_q <= win_cnt_q + WCNT_W'(1);
                            win_err_q <= win_err_inc;
                        end
                    end

                    default: begin
                        state_q <= StSeed;
                    end
                endcase
            end

            // Clear has priority over a same-cycle increment.
            if (clear) begin
                err_count_q <= '0;
            end else if (count_err) begin
                err_count_q <= err_count_q + ERR_W'(1);
            end
        end
    end

    assign locked    = (state_q == StCheck);
    assign bit_err   = bit_err_q;
    assign lock_lost = lock_lost_q;
    assign err_count = err_count_q;
    // All-ones history is the XNOR lockup fixed point; flag it but keep checking.
    assign stuck     = locked & (&hist_q);

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker. Two instances share the stimulus: the
// default configuration and a small saturating one (ERR_W=4, no loss of lock).
// A reference model built on the received-bit history predicts every cycle's
// outputs; a monitor pops and compares them on the falling edge.
module tb_lfsr_checker;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        linein = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;

    logic        locked, bit_err, lock_lost, stuck;
    logic [15:0] err_count;
    logic        s_locked, s_bit_err, s_lock_lost, s_stuck;
    logic [3:0]  s_err_count;

    always #5 clk = ~clk;

    lfsr_checker #(
        .WIDTH(4), .ERR_W(16), .WINDOW(16), .LOSS_THRESH(4)
    ) dut (
        .clk(clk), .reset(reset), .linein(linein), .enable(enable), .clear(clear),
        .locked(locked), .bit_err(bit_err), .err_count(err_count),
        .lock_lost(lock_lost), .stuck(stuck)
    );

    lfsr_checker #(
        .WIDTH(4), .ERR_W(4), .WINDOW(16), .LOSS_THRESH(17)
    ) dut_sat (
        .clk(clk), .reset(reset), .linein(linein), .enable(enable), .clear(clear),
        .locked(s_locked), .bit_err(s_bit_err), .err_count(s_err_count),
        .lock_lost(s_lock_lost), .stuck(s_stuck)
    );

    typedef struct packed {
        logic [19:0] m;
        logic [19:0] s;
    } exp_t;

    exp_t exp_q[$];
    bit   rx[$];                 // every enabled bit since the last reset

    int   cfg_win[2] = '{16, 16};
    int   cfg_thr[2] = '{4, 17};
    int   cfg_max[2] = '{65535, 15};

    bit   m_locked[2];
    int   m_seeded[2];
    int   m_wn[2];
    int   m_we[2];
    int   m_errs[2];
    bit   e_berr[2];
    bit   e_ll[2];

    int   n_checks = 0;
    int   n_pass = 0;
    int   berr_seen = 0;
    int   ll_seen = 0;

    logic [14:0] pat = 15'b000011101100101;
    int   k = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endfunction

    function automatic bit nb();
        bit v;
        v = pat[14 - (k % 15)];
        k++;
        return v;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_locked[m] = 1'b0;
            m_seeded[m] = 0;
            m_wn[m]     = 0;
            m_we[m]     = 0;
            m_errs[m]   = 0;
            e_berr[m]   = 1'b0;
            e_ll[m]     = 1'b0;
        end
        rx.delete();
    endfunction

    // Bit n of the line must equal ~(s(n-W) ^ s(n-W+1)) once synchronised.
    function automatic void model_step(int m, bit en, bit b, bit clr);
        int n;
        bit pred, mis;
        n = rx.size() - 1;
        e_berr[m] = 1'b0;
        e_ll[m]   = 1'b0;
        if (en) begin
            if (!m_locked[m]) begin
                m_seeded[m]++;
                if (m_seeded[m] == W) begin
                    m_locked[m] = 1'b1;
                    m_seeded[m] = 0;
                    m_wn[m] = 0;
                    m_we[m] = 0;
                end
            end else begin
                pred = !(rx[n-W] ^ rx[n-W+1]);
                mis  = (b != pred);
                e_berr[m] = mis;
                if (mis && m_errs[m] < cfg_max[m]) m_errs[m]++;
                m_wn[m]++;
                if (mis) m_we[m]++;
                if (m_we[m] == cfg_thr[m]) begin
                    e_ll[m] = 1'b1;
                    m_locked[m] = 1'b0;
                    m_seeded[m] = 0;
                end else if (m_wn[m] == cfg_win[m]) begin
                    m_wn[m] = 0;
                    m_we[m] = 0;
                end
            end
        end
        if (clr) m_errs[m] = 0;
    endfunction

    function automatic bit exp_stuck(int m);
        if (!m_locked[m]) return 1'b0;
        for (int i = 1; i <= W; i++) if (!rx[rx.size() - i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [19:0] pack(int m);
        return {m_locked[m], e_berr[m], e_ll[m], exp_stuck(m), 16'(m_errs[m])};
    endfunction

    task automatic cycle(bit en, bit b, bit clr, bit rst_n = 1'b1);
        exp_t e;
        @(negedge clk);
        reset  = rst_n;
        enable = en;
        linein = b;
        clear  = clr;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (en) rx.push_back(b);
            model_step(0, en, b, clr);
            model_step(1, en, b, clr);
        end
        e.m = pack(0);
        e.s = pack(1);
        exp_q.push_back(e);
        #1;
        if (bit_err) berr_seen++;
        if (lock_lost) ll_seen++;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        reset  = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        #1;
        chk("async_rst_main", 32'({locked, bit_err, lock_lost, stuck, err_count}), 32'd0);
        chk("async_rst_sat", 32'({s_locked, s_bit_err, s_lock_lost, s_stuck, s_err_count}),
            32'd0);
        model_reset();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("main_outputs", 32'({locked, bit_err, lock_lost, stuck, err_count}),
                32'(e.m));
            chk("sat_outputs",
                32'({s_locked, s_bit_err, s_lock_lost, s_stuck, 12'd0, s_err_count}),
                32'(e.s));
        end
    end

    initial begin
        int b0;
        bit b;
        model_reset();
        #1;
        chk("reset_main", 32'({locked, bit_err, lock_lost, stuck, err_count}), 32'd0);
        chk("reset_sat", 32'({s_locked, s_bit_err, s_lock_lost, s_stuck, s_err_count}), 32'd0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Lock and clean run: four periods of the WIDTH=4 sequence.
        for (int i = 0; i < 60; i++) begin
            cycle(1'b1, nb(), 1'b0);
            if (i == 2) chk("unlocked_after_3", 32'(locked), 32'd0);
            if (i == 3) chk("locked_after_4", 32'(locked), 32'd1);
        end
        chk("clean_err_count", 32'(err_count), 32'd0);
        chk("clean_bit_err", 32'(berr_seen), 32'd0);
        chk("clean_lock_lost", 32'(ll_seen), 32'd0);

        // Single flipped bit (10th of this run) gives three error pulses.
        b0 = berr_seen;
        for (int i = 0; i < 30; i++) begin
            b = nb();
            if (i == 9) b = ~b;
            cycle(1'b1, b, 1'b0);
        end
        chk("flip_pulses", 32'(berr_seen - b0), 32'd3);
        chk("flip_err_count", 32'(err_count), 32'd3);
        chk("flip_locked", 32'(locked), 32'd1);

        // Loss of lock: two flips six bits apart inside one window.
        cycle(1'b0, 1'b0, 1'b1);
        chk("clear_idle", 32'(err_count), 32'd0);
        for (int i = 0; i < 13; i++) begin
            b = nb();
            if (i == 2 || i == 8) b = ~b;
            cycle(1'b1, b, 1'b0);
            if (i == 8) chk("lost_unlocked", 32'(locked), 32'd0);
            if (i == 11) chk("relock_not_yet", 32'(locked), 32'd0);
        end
        chk("relocked", 32'(locked), 32'd1);
        chk("lost_err_count", 32'(err_count), 32'd4);
        chk("lost_pulses", 32'(ll_seen), 32'd1);
        repeat (10) cycle(1'b1, nb(), 1'b0);

        // Strobe gating with garbage on idle cycles.
        b0 = berr_seen;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) cycle(1'b1, nb(), 1'b0);
            else cycle(1'b0, bit'($urandom_range(0, 1)), 1'b0);
        end
        chk("gated_no_err", 32'(berr_seen - b0), 32'd0);
        chk("gated_count", 32'(err_count), 32'd4);

        // Clear coinciding with a mismatch.
        cycle(1'b1, ~nb(), 1'b1);
        chk("clear_vs_mismatch", 32'(err_count), 32'd0);
        chk("clear_bit_err", 32'(bit_err), 32'd1);
        repeat (2) cycle(1'b1, nb(), 1'b0);
        chk("clear_held", 32'(err_count), 32'd0);

        // Mid-stream reset, then reseed from the stream.
        async_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) cycle(1'b1, nb(), 1'b0);
        chk("reseed_locked", 32'(locked), 32'd1);
        chk("reseed_clean", 32'(err_count), 32'd0);

        // Lockup: all ones after reset.
        async_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        b0 = berr_seen;
        for (int i = 0; i < 24; i++) cycle(1'b1, 1'b1, 1'b0);
        chk("lockup_locked", 32'(locked), 32'd1);
        chk("lockup_stuck", 32'(stuck), 32'd1);
        chk("lockup_no_err", 32'(berr_seen - b0), 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 49) == 0));
        end

        // Saturation of the small counter.
        for (int i = 0; i < 120; i++) cycle(1'b1, bit'($urandom_range(0, 1)), 1'b0);
        chk("sat_count", 32'(s_err_count), 32'd15);

        @(negedge clk);
        @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
